wb_qpi_slave_bridge: RTL and testbench

Wishbone B4 pipelined slave that converts single-word bus requests into commands on the QPI memory controller request interface (`qpi_do_read` / `qpi_do_write` / `qpi_next_word`). It is the inverse of the QPI-to-SDRAM adapter: it lets any Wishbone master in the SoC reach PSRAM/flash behind the QPI controller. It accepts one outstanding request and emulates byte selects with read-modify-write.

---
 rtl/wb_qpi_slave_bridge_pkg.sv | 27 ++
 rtl/wb_qpi_slave_bridge_if.sv | 39 +++
 rtl/wb_qpi_slave_bridge_byte_merge.sv | 11 +
 rtl/wb_qpi_slave_bridge.sv | 145 ++++++++++++++
 tb/tb_wb_qpi_slave_bridge.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_qpi_slave_bridge_pkg.sv
// Shared types for the Wishbone-to-QPI bridge: FSM encoding, QPI address width, byte merge.
package qpi_bridge_pkg;

   localparam int QPI_AW = 25;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      WR     = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Byte i comes from new_dat when sel[i] is set, otherwise from old_dat.
   function automatic logic [31:0] byte_merge(input logic [3:0]  sel,
                                              input logic [31:0] new_dat,
                                              input logic [31:0] old_dat);
      logic [31:0] r;
      r = old_dat;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = sel[i] ? new_dat[8*i +: 8] : old_dat[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_qpi_slave_bridge_if.sv
// Wishbone B4 pipelined slave port plus QPI controller request port of the bridge.
interface wb_qpi_slave_bridge_if
   import qpi_bridge_pkg::*;
#(
   parameter int AW = 23
);
   logic              i_wb_cyc;
   logic              i_wb_stb;
   logic              i_wb_we;
   logic [AW-1:0]     i_wb_addr;
   logic [3:0]        i_wb_sel;
   logic [31:0]       i_wb_data;
   logic              o_wb_stall;
   logic              o_wb_ack;
   logic              o_wb_err;
   logic [31:0]       o_wb_data;

   logic              qpi_do_read;
   logic              qpi_do_write;
   logic [QPI_AW-1:0] qpi_addr;
   logic [31:0]       qpi_wdata;
   logic [31:0]       qpi_rdata;
   logic              qpi_next_word;
   logic              qpi_is_idle;

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_data,
      output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
      output qpi_do_read, qpi_do_write, qpi_addr, qpi_wdata,
      input  qpi_rdata, qpi_next_word, qpi_is_idle
   );

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_data,
      input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
      input  qpi_do_read, qpi_do_write, qpi_addr, qpi_wdata,
      output qpi_rdata, qpi_next_word, qpi_is_idle
   );
endinterface

// File: rtl/wb_qpi_slave_bridge_byte_merge.sv
// Combinational 32-bit byte-select merge; zero latency, no flow control.
module wb_byte_merge
   import qpi_bridge_pkg::*;
(
   input  logic [3:0]  sel_i,
   input  logic [31:0] new_dat_i,
   input  logic [31:0] old_dat_i,
   output logic [31:0] merged_o
);
   assign merged_o = byte_merge(sel_i, new_dat_i, old_dat_i);
endmodule

// File: rtl/wb_qpi_slave_bridge.sv
// Wishbone single-outstanding slave -> QPI read/write commands, partial writes via read-modify-write.
// do_* rise the cycle after accept; ack the cycle after next_word; optional WB_QPI_BRIDGE_TIMEOUT_EN.
module wb_qpi_slave_bridge
   import qpi_bridge_pkg::*;
#(
   parameter int AW      = 23,
   parameter int TIMEOUT = 255
)(
   input  logic                  clk,
   input  logic                  rst,
   wb_qpi_slave_bridge_if.slave  bus
);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   buf_q, buf_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          merged_q, merged_d;
   logic          err_q, err_d;
   logic [31:0]   merged_word;
   logic          do_rd, do_wr, ack;
   logic [AW+26:0] addr_ext;

`ifdef WB_QPI_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   wb_byte_merge u_merge (
      .sel_i     (sel_q),
      .new_dat_i (buf_q),
      .old_dat_i (bus.qpi_rdata),
      .merged_o  (merged_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         sel_q    <= '0;
         buf_q    <= '0;
         rdata_q  <= '0;
         merged_q <= 1'b0;
         err_q    <= 1'b0;
`ifdef WB_QPI_BRIDGE_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         buf_q    <= buf_d;
         rdata_q  <= rdata_d;
         merged_q <= merged_d;
         err_q    <= err_d;
`ifdef WB_QPI_BRIDGE_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      sel_d    = sel_q;
      buf_d    = buf_q;
      rdata_d  = rdata_q;
      merged_d = merged_q;
      err_d    = 1'b0;
      do_rd    = 1'b0;
      do_wr    = 1'b0;
      ack      = 1'b0;

      case (state_q)
         IDLE: begin
            merged_d = 1'b0;
            if (bus.i_wb_cyc && bus.i_wb_stb && bus.qpi_is_idle) begin
               addr_d = bus.i_wb_addr;
               sel_d  = bus.i_wb_sel;
               buf_d  = bus.i_wb_data;
               if (!bus.i_wb_we)                state_d = RD;
               else if (bus.i_wb_sel == 4'hF)   state_d = WR;
               else if (bus.i_wb_sel == 4'h0)   state_d = DONE;
               else                             state_d = RMW_RD;
            end
         end
         RD: begin
            do_rd = 1'b1;
            if (bus.qpi_next_word) begin
               rdata_d = bus.qpi_rdata;
               state_d = DONE;
            end
         end
         RMW_RD: begin
            // After the read word lands, hold off the write until the controller reports idle.
            do_rd = !merged_q;
            if (!merged_q && bus.qpi_next_word) begin
               buf_d    = merged_word;
               merged_d = 1'b1;
            end
            if (merged_q && bus.qpi_is_idle) begin
               state_d = RMW_WR;
            end
         end
         WR, RMW_WR: begin
            do_wr = 1'b1;
            if (bus.qpi_next_word) state_d = DONE;
         end
         DONE: begin
            ack     = bus.i_wb_cyc;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

`ifdef WB_QPI_BRIDGE_TIMEOUT_EN
      cnt_d = (do_rd || do_wr) ? cnt_q + CNT_W'(1) : '0;
      if ((do_rd || do_wr) && !bus.qpi_next_word && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
         state_d  = IDLE;
         merged_d = 1'b0;
         err_d    = bus.i_wb_cyc;
      end
`endif
   end

   assign addr_ext = {{25{1'b0}}, addr_q, 2'b00};

   assign bus.o_wb_stall   = rst || (state_q != IDLE) || !bus.qpi_is_idle;
   assign bus.o_wb_ack     = ack;
   assign bus.o_wb_data    = rdata_q;
   assign bus.qpi_do_read  = do_rd;
   assign bus.qpi_do_write = do_wr;
   assign bus.qpi_addr     = addr_ext[QPI_AW-1:0];
   assign bus.qpi_wdata    = buf_q;
`ifdef WB_QPI_BRIDGE_TIMEOUT_EN
   assign bus.o_wb_err     = err_q;
`else
   assign bus.o_wb_err     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_qpi_slave_bridge.sv
// Directed bench for wb_qpi_slave_bridge: reads, full/partial/empty writes, cyc drop, reset, timeout.
module tb_wb_qpi_slave_bridge;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   wb_qpi_slave_bridge_if #(.AW(23)) bus ();

   wb_qpi_slave_bridge #(.AW(23), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [22:0] addr, input logic [3:0] sel,
                        input logic [31:0] dat);
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_we   = we;
      bus.i_wb_addr = addr;
      bus.i_wb_sel  = sel;
      bus.i_wb_data = dat;
      step();
      bus.i_wb_stb  = 1'b0;
      #1;
   endtask

   task automatic deliver(input logic [31:0] rd);
      bus.qpi_rdata     = rd;
      bus.qpi_next_word = 1'b1;
      step();
      bus.qpi_next_word = 1'b0;
      #1;
   endtask

   initial begin
      rst               = 1'b1;
      bus.i_wb_cyc      = 1'b0;
      bus.i_wb_stb      = 1'b0;
      bus.i_wb_we       = 1'b0;
      bus.i_wb_addr     = '0;
      bus.i_wb_sel      = 4'h0;
      bus.i_wb_data     = '0;
      bus.qpi_rdata     = '0;
      bus.qpi_next_word = 1'b0;
      bus.qpi_is_idle   = 1'b1;
      #1;
      chk("rst_stall", 32'(bus.o_wb_stall), 32'd1);
      step();
      chk("rst_do_read",  32'(bus.qpi_do_read),  32'd0);
      chk("rst_do_write", 32'(bus.qpi_do_write), 32'd0);
      chk("rst_ack",      32'(bus.o_wb_ack),     32'd0);
      chk("rst_err",      32'(bus.o_wb_err),     32'd0);
      chk("rst_rdata",    bus.o_wb_data,         32'd0);
      chk("rst_addr",     32'(bus.qpi_addr),     32'd0);
      chk("rst_wdata",    bus.qpi_wdata,         32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("idle_stall", 32'(bus.o_wb_stall), 32'd0);

      // Plain read, controller answers in the fifth command cycle
      issue(1'b0, 23'h000010, 4'hF, 32'h0);
      chk("rd_do_read", 32'(bus.qpi_do_read),  32'd1);
      chk("rd_do_wr",   32'(bus.qpi_do_write), 32'd0);
      chk("rd_addr",    32'(bus.qpi_addr),     32'h40);
      chk("rd_stall",   32'(bus.o_wb_stall),   32'd1);
      for (int i = 0; i < 4; i++) step();
      chk("rd_hold", 32'(bus.qpi_do_read), 32'd1);
      chk("rd_noack", 32'(bus.o_wb_ack), 32'd0);
      deliver(32'hDEADBEEF);
      chk("rd_ack",     32'(bus.o_wb_ack),    32'd1);
      chk("rd_data",    bus.o_wb_data,        32'hDEADBEEF);
      chk("rd_drop",    32'(bus.qpi_do_read), 32'd0);
      step();
      chk("rd_ack_once", 32'(bus.o_wb_ack), 32'd0);

      // Full-word write
      issue(1'b1, 23'h000003, 4'hF, 32'h12345678);
      chk("wr_do_write", 32'(bus.qpi_do_write), 32'd1);
      chk("wr_do_read",  32'(bus.qpi_do_read),  32'd0);
      chk("wr_addr",     32'(bus.qpi_addr),     32'hC);
      chk("wr_wdata",    bus.qpi_wdata,         32'h12345678);
      step();
      chk("wr_hold", 32'(bus.qpi_do_write), 32'd1);
      deliver(32'h0);
      chk("wr_ack",  32'(bus.o_wb_ack),     32'd1);
      chk("wr_drop", 32'(bus.qpi_do_write), 32'd0);
      step();
      chk("wr_ack_once", 32'(bus.o_wb_ack), 32'd0);

      // Partial write: read 0x11223344, merge sel 0101 of 0xAABBCCDD
      issue(1'b1, 23'h000005, 4'b0101, 32'hAABBCCDD);
      chk("rmw_do_read", 32'(bus.qpi_do_read),  32'd1);
      chk("rmw_no_wr",   32'(bus.qpi_do_write), 32'd0);
      bus.qpi_is_idle = 1'b0;
      deliver(32'h11223344);
      chk("rmw_rd_drop", 32'(bus.qpi_do_read),  32'd0);
      chk("rmw_wait_wr", 32'(bus.qpi_do_write), 32'd0);
      step();
      chk("rmw_busy_wr", 32'(bus.qpi_do_write), 32'd0);
      bus.qpi_is_idle = 1'b1;
      step();
      chk("rmw_do_write", 32'(bus.qpi_do_write), 32'd1);
      chk("rmw_wdata",    bus.qpi_wdata,         32'h11BB33DD);
      chk("rmw_addr",     32'(bus.qpi_addr),     32'h14);
      chk("rmw_noack",    32'(bus.o_wb_ack),     32'd0);
      deliver(32'h0);
      chk("rmw_ack", 32'(bus.o_wb_ack), 32'd1);
      step();

      // Empty write: stalled while controller busy, then acked in cycle 1
      bus.qpi_is_idle = 1'b0;
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      bus.i_wb_we  = 1'b1;
      bus.i_wb_sel = 4'h0;
      #1;
      chk("sel0_stall_busy", 32'(bus.o_wb_stall), 32'd1);
      step();
      chk("sel0_not_taken", 32'(bus.o_wb_ack), 32'd0);
      bus.qpi_is_idle = 1'b1;
      #1;
      chk("sel0_stall_free", 32'(bus.o_wb_stall), 32'd0);
      step();
      bus.i_wb_stb = 1'b0;
      #1;
      chk("sel0_ack",   32'(bus.o_wb_ack),                        32'd1);
      chk("sel0_no_do", 32'({bus.qpi_do_read, bus.qpi_do_write}), 32'd0);
      step();
      chk("sel0_ack_once", 32'(bus.o_wb_ack), 32'd0);

      // Cycle dropped mid-read: command finishes silently, next read unaffected
      issue(1'b0, 23'h000020, 4'hF, 32'h0);
      bus.i_wb_cyc = 1'b0;
      #1;
      chk("drop_do_read", 32'(bus.qpi_do_read), 32'd1);
      step();
      deliver(32'hCAFEF00D);
      chk("drop_noack", 32'(bus.o_wb_ack),    32'd0);
      chk("drop_rd_lo", 32'(bus.qpi_do_read), 32'd0);
      step();
      issue(1'b0, 23'h000021, 4'hF, 32'h0);
      chk("next_addr",    32'(bus.qpi_addr),    32'h84);
      chk("next_do_read", 32'(bus.qpi_do_read), 32'd1);
      deliver(32'h01020304);
      chk("next_ack",  32'(bus.o_wb_ack), 32'd1);
      chk("next_data", bus.o_wb_data,     32'h01020304);
      step();

      // Stray next_word in IDLE is ignored
      deliver(32'h55555555);
      chk("stray_noack", 32'(bus.o_wb_ack), 32'd0);
      chk("stray_data",  bus.o_wb_data,     32'h01020304);

      // Reset during an active read abandons it
      issue(1'b0, 23'h000001, 4'hF, 32'h0);
      chk("mid_rst_pre", 32'(bus.qpi_do_read), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_stall", 32'(bus.o_wb_stall), 32'd1);
      step();
      chk("mid_rst_drop", 32'(bus.qpi_do_read), 32'd0);
      rst = 1'b0;
      step();

`ifdef WB_QPI_BRIDGE_TIMEOUT_EN
      begin
         int hi_cnt  = 0;
         int err_cnt = 0;
         int ack_cnt = 0;
         issue(1'b0, 23'h000002, 4'hF, 32'h0);
         for (int i = 0; i < 40; i++) begin
            if (bus.qpi_do_read) hi_cnt++;
            if (bus.o_wb_err) err_cnt++;
            if (bus.o_wb_ack) ack_cnt++;
            step();
         end
         chk("to_cycles", 32'(hi_cnt),  32'd16);
         chk("to_err",    32'(err_cnt), 32'd1);
         chk("to_noack",  32'(ack_cnt), 32'd0);
      end
`else
      begin
         int err_cnt = 0;
         issue(1'b0, 23'h000002, 4'hF, 32'h0);
         for (int i = 0; i < 40; i++) begin
            if (bus.o_wb_err) err_cnt++;
            step();
         end
         chk("nto_err",  32'(err_cnt),         32'd0);
         chk("nto_wait", 32'(bus.qpi_do_read), 32'd1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
